alu_control_seq: RTL and testbench

- Registered, handshaked successor to the combinational ALU-control decoder.
- Accepts {ALUop, instruction} from the decode stage, decodes the full R-type opcode field instruction[31:21] into an OPT_W-bit ALU operation, and holds it for the execute stage under valid/ready.
- Extends the op set with EOR, LSL, LSR and MUL, and flags illegal R-type opcodes with a saturating counter.
- MUL is multi-cycle: the block stalls new issues for MUL_CYCLES-1 cycles after a MUL is consumed.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_control_seq_if.sv | 28 ++
 rtl/alu_op_decode.sv | 41 ++++
 rtl/alu_control_seq.sv | 124 ++++++++++++
 tb/tb_alu_control_seq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: base op codes, R-type opcodes, FSM states.
package alu_pkg;

    // Base 4-bit ALU operation codes, zero-extended to OPT_W by users
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_EOR   = 4'b0011;
    localparam logic [3:0] OP_LSL   = 4'b0100;
    localparam logic [3:0] OP_LSR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    // R-type opcode field, instruction[31:21]
    localparam logic [10:0] RT_ADD = 11'b10001011000;
    localparam logic [10:0] RT_SUB = 11'b11001011000;
    localparam logic [10:0] RT_AND = 11'b10001010000;
    localparam logic [10:0] RT_ORR = 11'b10101010000;
    localparam logic [10:0] RT_EOR = 11'b11001010000;
    localparam logic [10:0] RT_LSL = 11'b11010011011;
    localparam logic [10:0] RT_LSR = 11'b11010011010;
    localparam logic [10:0] RT_MUL = 11'b10011011000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_MUL  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_control_seq_if.sv
// Decode-side request and execute-side response bundle of the ALU-control stage.
interface alu_control_seq_if #(
    parameter int OPT_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUop;
    logic [31:0]      instruction;
    logic             out_valid;
    logic             out_ready;
    logic [OPT_W-1:0] opt;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] illegal_cnt;

    // Environment side: presents instructions and consumes decoded ops
    modport master (
        output in_valid, ALUop, instruction, out_ready,
        input  in_ready, out_valid, opt, illegal, busy, illegal_cnt
    );

    // Block side: the ALU-control stage itself
    modport slave (
        input  in_valid, ALUop, instruction, out_ready,
        output in_ready, out_valid, opt, illegal, busy, illegal_cnt
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational {ALUop, R-type opcode} -> ALU op decoder, shared with the hazard unit.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int               OPT_W       = 4,
    parameter logic [OPT_W-1:0] ILLEGAL_OPT = '1
) (
    input  logic [1:0]       aluop_i,
    input  logic [10:0]      opcode_i,
    output logic [OPT_W-1:0] opt_o,
    output logic             illegal_o,
    output logic             is_mul_o
);
    logic [3:0] code;

    // Priority decode: ALUop[0] forces PASS_B, 00 is address ADD, 10 looks at the opcode
    always_comb begin
        code      = OP_ADD;
        illegal_o = 1'b0;
        is_mul_o  = 1'b0;
        if (aluop_i[0]) begin
            code = OP_PASSB;
        end else if (aluop_i[1]) begin
            case (opcode_i)
                RT_ADD:  code = OP_ADD;
                RT_SUB:  code = OP_SUB;
                RT_AND:  code = OP_AND;
                RT_ORR:  code = OP_ORR;
                RT_EOR:  code = OP_EOR;
                RT_LSL:  code = OP_LSL;
                RT_LSR:  code = OP_LSR;
                RT_MUL: begin
                    code     = OP_MUL;
                    is_mul_o = 1'b1;
                end
                default: illegal_o = 1'b1;
            endcase
        end
        opt_o = illegal_o ? ILLEGAL_OPT : OPT_W'(code);
    end
endmodule

// File: rtl/alu_control_seq.sv
// Registered, valid/ready ALU-control stage with multiply stall and illegal-op counter.
module alu_control_seq
    import alu_pkg::*;
#(
    parameter int               OPT_W       = 4,
    parameter int               MUL_CYCLES  = 4,
    parameter int               CNT_W       = 8,
    parameter logic [OPT_W-1:0] ILLEGAL_OPT = '1
) (
    input logic               clk,
    input logic               rst,
    alu_control_seq_if.slave  bus
);
    localparam int MC_W       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam bit MUL_STALLS = (MUL_CYCLES > 1);

    state_t           state_q, state_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic [OPT_W-1:0] opt_q;
    logic             illegal_q;
    logic             mul_held_q;
    logic [CNT_W-1:0] cnt_q;

    logic [OPT_W-1:0] dec_opt;
    logic             dec_illegal;
    logic             dec_is_mul;
    logic             in_ready;
    logic             accept;
    logic             unused_instr_bits;

    // Only instruction[31:21] takes part in the decode
    assign unused_instr_bits = ^bus.instruction[20:0];

    alu_op_decode #(
        .OPT_W       (OPT_W),
        .ILLEGAL_OPT (ILLEGAL_OPT)
    ) u_dec (
        .aluop_i   (bus.ALUop),
        .opcode_i  (bus.instruction[31:21]),
        .opt_o     (dec_opt),
        .illegal_o (dec_illegal),
        .is_mul_o  (dec_is_mul)
    );

    assign accept = bus.in_valid & in_ready;

    // State register and multiply countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Held op, its MUL tag and the saturating illegal counter, all loaded on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            opt_q      <= ILLEGAL_OPT;
            illegal_q  <= 1'b0;
            mul_held_q <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            opt_q      <= dec_opt;
            illegal_q  <= dec_illegal;
            // With a single-cycle multiplier a MUL is just another op
            mul_held_q <= dec_is_mul & MUL_STALLS;
            if (dec_illegal && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state: hold until consumed, then idle, chain back-to-back, or enter the MUL stall
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    if (mul_held_q) begin
                        state_d = S_MUL;
                        mcnt_d  = MC_W'(MUL_CYCLES - 1);
                    end else if (accept) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_MUL: begin
                mcnt_d = mcnt_q - MC_W'(1);
                if (mcnt_q == MC_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs from the current state; a held MUL blocks issue until the stall starts
    always_comb begin
        in_ready      = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_HOLD: begin
                bus.out_valid = 1'b1;
                in_ready      = bus.out_ready & ~mul_held_q;
            end
            S_MUL:  bus.busy = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign bus.in_ready    = in_ready;
    assign bus.opt         = opt_q;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: one stalling instance (MUL_CYCLES=4, CNT_W=2)
// and one single-cycle-multiply instance (MUL_CYCLES=1).
module tb_alu_control_seq;

    typedef struct packed {
        logic [3:0] opt;
        logic       ill;
        logic [1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_control_seq_if #(.OPT_W(4), .CNT_W(2)) ifa ();
    alu_control_seq_if #(.OPT_W(4), .CNT_W(8)) ifb ();

    alu_control_seq #(.OPT_W(4), .MUL_CYCLES(4), .CNT_W(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    alu_control_seq #(.OPT_W(4), .MUL_CYCLES(1), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode table: {illegal, opt}
    function automatic logic [4:0] model_dec(input logic [1:0] a, input logic [31:0] ins);
        logic [10:0] opc;
        opc = ins[31:21];
        if (a[0]) return 5'b0_0111;
        if (a == 2'b00) return 5'b0_0010;
        case (opc)
            11'b10001011000: return 5'b0_0010;
            11'b11001011000: return 5'b0_0110;
            11'b10001010000: return 5'b0_0000;
            11'b10101010000: return 5'b0_0001;
            11'b11001010000: return 5'b0_0011;
            11'b11010011011: return 5'b0_0100;
            11'b11010011010: return 5'b0_0101;
            11'b10011011000: return 5'b0_1000;
            default:         return 5'b1_1111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op to dut_a; called just after a rising edge, returns just after the accept edge
    task automatic send_a(input logic [1:0] a, input logic [10:0] opc, output int waits);
        logic [4:0] d;
        exp_t       e;
        bit         accepted;
        accepted        = 1'b0;
        waits           = 0;
        ifa.ALUop       = a;
        ifa.instruction = {opc, 21'($urandom)};
        ifa.in_valid    = 1'b1;
        d = model_dec(a, ifa.instruction);
        while (!accepted && waits <= 40) begin
            @(negedge clk);
            if (ifa.in_ready) begin
                accepted = 1'b1;
                if (d[4]) exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
                e.opt = d[3:0];
                e.ill = d[4];
                e.cnt = 2'(exp_cnt);
                sbq.push_back(e);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        ifa.in_valid = 1'b0;
        if (!accepted) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Compare every op the execute side consumes against the scoreboard
    always @(negedge clk) begin
        if (!rst && ifa.out_valid && ifa.out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'(sbq.size()), 32'd1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_opt", 32'(ifa.opt), 32'(e.opt));
                chk("sb_illegal", 32'(ifa.illegal), 32'(e.ill));
                chk("sb_cnt", 32'(ifa.illegal_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int nb;
        bit done;
        logic [10:0] opc_tab [7];
        opc_tab = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                    11'b11001010000, 11'b11010011011, 11'b11010011010};

        // Reset with a pending request on the bus
        ifa.in_valid    = 1'b1;
        ifa.ALUop       = 2'b10;
        ifa.instruction = {11'b10001011000, 21'd0};
        ifa.out_ready   = 1'b1;
        ifb.in_valid    = 1'b0;
        ifb.ALUop       = 2'b00;
        ifb.instruction = 32'd0;
        ifb.out_ready   = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_during_ovalid", 32'(ifa.out_valid), 32'd0);
        step();
        rst = 1'b0;
        ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ovalid", 32'(ifa.out_valid), 32'd0);
        chk("rst_opt", 32'(ifa.opt), 32'hf);
        chk("rst_cnt", 32'(ifa.illegal_cnt), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_ready", 32'(ifa.in_ready), 32'd1);
        chk("rst_b_opt", 32'(ifb.opt), 32'hf);
        step();

        // Full decode table back-to-back
        for (int i = 0; i < 7; i++) begin
            send_a(2'b10, opc_tab[i], w);
            chk("b2b_wait", 32'(w), 32'd0);
        end
        send_a(2'b00, 11'($urandom), w);
        chk("b2b_wait", 32'(w), 32'd0);
        send_a(2'b01, 11'b11001011000, w);
        chk("b2b_wait", 32'(w), 32'd0);
        send_a(2'b11, 11'($urandom), w);
        chk("b2b_wait", 32'(w), 32'd0);
        repeat (3) step();

        // Backpressure: ADD held while ORR waits
        send_a(2'b10, 11'b10001011000, w);
        ifa.out_ready   = 1'b0;
        ifa.ALUop       = 2'b10;
        ifa.instruction = {11'b10101010000, 21'd0};
        ifa.in_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_opt", 32'(ifa.opt), 32'h2);
            chk("bp_ready", 32'(ifa.in_ready), 32'd0);
            chk("bp_ovalid", 32'(ifa.out_valid), 32'd1);
            step();
        end
        ifa.out_ready = 1'b1;
        send_a(2'b10, 11'b10101010000, w);
        chk("bp_accept_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk("bp_orr_opt", 32'(ifa.opt), 32'h1);
        step();
        repeat (2) step();

        // MUL stall on the MUL_CYCLES=4 instance
        send_a(2'b10, 11'b10011011000, w);
        @(negedge clk);
        chk("mul_hold_ready", 32'(ifa.in_ready), 32'd0);
        chk("mul_hold_opt", 32'(ifa.opt), 32'h8);
        step();
        nb   = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (ifa.busy) begin
                nb++;
                chk("mul_busy_ready", 32'(ifa.in_ready), 32'd0);
                chk("mul_busy_ovalid", 32'(ifa.out_valid), 32'd0);
                step();
            end else begin
                done = 1'b1;
            end
        end
        chk("mul_busy_cycles", 32'(nb), 32'd3);
        chk("mul_end_ready", 32'(ifa.in_ready), 32'd1);
        chk("mul_end_ovalid", 32'(ifa.out_valid), 32'd0);
        step();

        // MUL on the MUL_CYCLES=1 instance behaves like any other op
        ifb.ALUop       = 2'b10;
        ifb.instruction = {11'b10011011000, 21'h1234};
        ifb.in_valid    = 1'b1;
        @(negedge clk);
        chk("m1_ready_idle", 32'(ifb.in_ready), 32'd1);
        step();
        ifb.instruction = {11'b10001011000, 21'd0};
        @(negedge clk);
        chk("m1_mul_opt", 32'(ifb.opt), 32'h8);
        chk("m1_hold_ready", 32'(ifb.in_ready), 32'd1);
        chk("m1_busy0", 32'(ifb.busy), 32'd0);
        step();
        ifb.in_valid = 1'b0;
        @(negedge clk);
        chk("m1_next_opt", 32'(ifb.opt), 32'h2);
        chk("m1_busy1", 32'(ifb.busy), 32'd0);
        step();
        @(negedge clk);
        chk("m1_idle_ovalid", 32'(ifb.out_valid), 32'd0);
        chk("m1_busy2", 32'(ifb.busy), 32'd0);
        step();

        // Illegal opcode saturation with CNT_W=2: 1,2,3,3,3 checked by the scoreboard
        for (int i = 0; i < 5; i++) begin
            send_a(2'b10, 11'b11111111111, w);
            chk("ill_wait", 32'(w), 32'd0);
        end
        repeat (2) step();
        @(negedge clk);
        chk("sat_cnt", 32'(ifa.illegal_cnt), 32'd3);
        step();

        // Reset in the second busy cycle of a MUL
        send_a(2'b10, 11'b10011011000, w);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rm_busy_pre", 32'(ifa.busy), 32'd1);
        step();
        rst     = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("rm_busy", 32'(ifa.busy), 32'd0);
        chk("rm_ovalid", 32'(ifa.out_valid), 32'd0);
        chk("rm_ready", 32'(ifa.in_ready), 32'd1);
        chk("rm_cnt", 32'(ifa.illegal_cnt), 32'd0);
        step();

        repeat (2) step();
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
